// File: rtl/mmio_uart_tx.sv
`default_nettype none
// ============================================================================
// mmio_uart_tx : memory-mapped TX FIFO plus 8N1 serialiser on the data port
// Revision 1.0 - initial release
// ============================================================================
module mmio_uart_tx #(
  parameter int                       DM_ADDRESS   = 9,
  parameter int                       DATA_W       = 32,
  parameter logic [DM_ADDRESS-1:0]    BASE_ADDR    = 9'h1F0,
  parameter int                       FIFO_DEPTH   = 8,
  parameter int                       CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_write,
  input  logic                  mem_read,
  input  logic [DM_ADDRESS-1:0] addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [2:0]            funct3,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  hit,
  output logic                  tx,
  output logic                  tx_busy
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  localparam logic [1:0] OFS_TXDATA = 2'd0;
  localparam logic [1:0] OFS_STATUS = 2'd1;
  localparam logic [1:0] OFS_CTRL   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              enable_q, enable_d;
  logic [7:0]        fifo_mem [FIFO_DEPTH];

  logic       wr_sel, push_req, push, pop, full, empty, baud_done;
  logic [1:0] offset;
  logic       unused_ok;

  assign hit       = (addr[DM_ADDRESS-1:4] == BASE_ADDR[DM_ADDRESS-1:4]);
  assign offset    = addr[3:2];
  assign wr_sel    = mem_write & hit;
  assign full      = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty     = (count_q == '0);
  assign push_req  = wr_sel & (offset == OFS_TXDATA);
  assign push      = push_req & ~full;
  assign pop       = (state_q == ST_IDLE) & enable_q & ~empty;
  assign baud_done = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
  assign tx        = tx_q;
  assign tx_busy   = (state_q != ST_IDLE);
  assign unused_ok = ^{funct3, addr[1:0], wr_data[DATA_W-1:8]};

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    enable_d   = enable_q;
    overflow_d = overflow_q;
    if (wr_sel && offset == OFS_CTRL) begin
      enable_d = wr_data[0];
      if (wr_data[1]) overflow_d = 1'b0;
    end
    // A dropped push must win over a same-edge W1C.
    if (push_req && full) overflow_d = 1'b1;
  end

  always_comb begin
    rd_data = '0;
    if (mem_read && hit) begin
      case (offset)
        OFS_STATUS: begin
          rd_data[0]   = full;
          rd_data[1]   = empty;
          rd_data[2]   = tx_busy;
          rd_data[3]   = overflow_q;
          rd_data[7:4] = 4'(count_q);
        end
        OFS_CTRL: rd_data[0] = enable_q;
        default:  rd_data = '0;
      endcase
    end
  end

  // tx_d is the line level for the state being entered, so tx stays a clean flop.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (pop) begin
          shift_d = fifo_mem[rd_ptr_q];
          baud_d  = '0;
          state_d = ST_START;
          tx_d    = 1'b0;
        end
      end
      ST_START: begin
        if (baud_done) begin
          baud_d    = '0;
          bit_idx_d = 3'd0;
          state_d   = ST_DATA;
          tx_d      = shift_q[0];
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      ST_DATA: begin
        if (baud_done) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      ST_STOP: begin
        if (baud_done) begin
          baud_d  = '0;
          state_d = ST_IDLE;
          tx_d    = 1'b1;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= wr_data[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      enable_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      enable_q   <= enable_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
`default_nettype none
// ============================================================================
// tb_mmio_uart_tx : register vectors, frame scoreboard and corner sequences
// Revision 1.0 - initial release
// ============================================================================
module tb_mmio_uart_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_write = 1'b0;
  logic        mem_read = 1'b0;
  logic [8:0]  addr = '0;
  logic [31:0] wr_data = '0;
  logic [2:0]  funct3 = '0;
  logic [31:0] rd_data;
  logic        hit, tx, tx_busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic mon_en = 1'b0;
  logic [7:0] sb_q[$];
  int start_q[$];

  mmio_uart_tx #(
    .DM_ADDRESS(9), .DATA_W(32), .BASE_ADDR(9'h1F0),
    .FIFO_DEPTH(8), .CLKS_PER_BIT(4)
  ) dut (
    .clk(clk), .reset(reset), .mem_write(mem_write), .mem_read(mem_read),
    .addr(addr), .wr_data(wr_data), .funct3(funct3), .rd_data(rd_data),
    .hit(hit), .tx(tx), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic bus(input logic w, input logic r, input logic [8:0] a, input logic [31:0] d,
                     input logic do_chk, input logic [31:0] exp_rd, input logic exp_hit,
                     input string nm);
    @(negedge clk);
    mem_write = w; mem_read = r; addr = a; wr_data = d;
    funct3 = 3'($urandom_range(0, 7));
    #1;
    if (do_chk) begin
      chk({nm, " rd_data"}, rd_data, exp_rd);
      chk({nm, " hit"}, hit, exp_hit);
    end
    @(posedge clk);
    #1;
    mem_write = 1'b0; mem_read = 1'b0;
  endtask

  task automatic store_tx(input logic [7:0] b, input logic accept);
    if (accept) sb_q.push_back(b);
    bus(1'b1, 1'b0, 9'h1F0, {24'hABCDEF, b}, 1'b0, 32'h0, 1'b1, "txdata");
  endtask

  task automatic wait_drain(input string nm);
    int n = 0;
    while (!(sb_q.size() == 0 && !tx_busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " drain timeout"}, (n >= 2000), 1'b0);
  endtask

  // Frame monitor: captures all 40 bit-cycles of each frame and scores it.
  initial begin
    logic [39:0] got, exp;
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (mon_en && !reset && tx === 1'b0) begin
        start_q.push_back(cyc);
        got = '0;
        for (int i = 1; i < 40; i++) begin
          @(negedge clk);
          got[i] = tx;
        end
        if (sb_q.size() == 0) begin
          chk("unexpected frame", {24'h0, got}, 64'h0);
        end else begin
          b = sb_q.pop_front();
          exp = '0;
          for (int k = 0; k < 8; k++) exp[4 + 4*k +: 4] = {4{b[k]}};
          exp[39:36] = 4'hF;
          chk("frame bits", {24'h0, got}, {24'h0, exp});
        end
      end
    end
  end

  typedef struct {
    logic        w;
    logic        r;
    logic [8:0]  a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic        exp_hit;
  } vec_t;

  vec_t vt[16];

  initial begin
    int n;
    int bad;
    vt[0]  = '{1'b0, 1'b1, 9'h1F4, 32'h0,        32'h2, 1'b1};
    vt[1]  = '{1'b0, 1'b1, 9'h1EC, 32'h0,        32'h0, 1'b0};
    vt[2]  = '{1'b0, 1'b1, 9'h1F8, 32'h0,        32'h0, 1'b1};
    vt[3]  = '{1'b0, 1'b1, 9'h1F0, 32'h0,        32'h0, 1'b1};
    vt[4]  = '{1'b1, 1'b0, 9'h1FC, 32'hFFFFFFFF, 32'h0, 1'b1};
    vt[5]  = '{1'b0, 1'b1, 9'h1FF, 32'h0,        32'h0, 1'b1};
    vt[6]  = '{1'b0, 1'b1, 9'h1FA, 32'h0,        32'h0, 1'b1};
    vt[7]  = '{1'b1, 1'b0, 9'h1E8, 32'h1,        32'h0, 1'b0};
    vt[8]  = '{1'b0, 1'b1, 9'h1F8, 32'h0,        32'h0, 1'b1};
    vt[9]  = '{1'b1, 1'b1, 9'h1F9, 32'h1,        32'h0, 1'b1};
    vt[10] = '{1'b0, 1'b1, 9'h1FB, 32'h0,        32'h1, 1'b1};
    vt[11] = '{1'b1, 1'b1, 9'h1F8, 32'h0,        32'h1, 1'b1};
    vt[12] = '{1'b0, 1'b1, 9'h1F8, 32'h0,        32'h0, 1'b1};
    vt[13] = '{1'b1, 1'b1, 9'h1F4, 32'hFFFF,     32'h2, 1'b1};
    vt[14] = '{1'b0, 1'b1, 9'h1F4, 32'h0,        32'h2, 1'b1};
    vt[15] = '{1'b0, 1'b0, 9'h1F4, 32'h0,        32'h0, 1'b1};

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset tx", tx, 1'b1);
    chk("reset tx_busy", tx_busy, 1'b0);
    mon_en = 1'b1;

    for (int i = 0; i < 16; i++)
      bus(vt[i].w, vt[i].r, vt[i].a, vt[i].d, 1'b1, vt[i].exp_rd, vt[i].exp_hit,
          $sformatf("vec%0d", i));

    // Single frame 0xA5: start latency and busy width.
    bus(1'b1, 1'b0, 9'h1F8, 32'h1, 1'b0, 32'h0, 1'b1, "en");
    store_tx(8'hA5, 1'b1);
    @(negedge clk);
    chk("tx high after store edge", tx, 1'b1);
    @(negedge clk);
    chk("tx low after pop edge", tx, 1'b0);
    n = 0;
    while (tx_busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("tx_busy cycles", n, 40);
    wait_drain("a5");

    // Fill with enable off, overflow on 9th byte, clear, then drain.
    bus(1'b1, 1'b0, 9'h1F8, 32'h0, 1'b0, 32'h0, 1'b1, "dis");
    for (int i = 0; i < 9; i++) store_tx(8'(i), (i < 8));
    bus(1'b0, 1'b1, 9'h1F4, 32'h0, 1'b1, 32'h89, 1'b1, "full status");
    bus(1'b1, 1'b0, 9'h1F8, 32'h2, 1'b0, 32'h0, 1'b1, "w1c");
    bus(1'b0, 1'b1, 9'h1F4, 32'h0, 1'b1, 32'h81, 1'b1, "after w1c");
    start_q.delete();
    bus(1'b1, 1'b0, 9'h1F8, 32'h1, 1'b0, 32'h0, 1'b1, "en");
    wait_drain("burst");
    chk("burst frame count", start_q.size(), 8);
    bad = 0;
    for (int i = 1; i < start_q.size(); i++)
      if (start_q[i] - start_q[i-1] != 41) bad++;
    chk("burst frame spacing", bad, 0);
    bus(1'b0, 1'b1, 9'h1F4, 32'h0, 1'b1, 32'h02, 1'b1, "burst end status");

    // Full FIFO: store lands on the same edge as the first pop and is dropped.
    bus(1'b1, 1'b0, 9'h1F8, 32'h0, 1'b0, 32'h0, 1'b1, "dis");
    for (int i = 0; i < 8; i++) store_tx(8'h10 + 8'(i), 1'b1);
    bus(1'b1, 1'b0, 9'h1F8, 32'h1, 1'b0, 32'h0, 1'b1, "en");
    store_tx(8'h99, 1'b0);
    bus(1'b0, 1'b1, 9'h1F4, 32'h0, 1'b1, 32'h7C, 1'b1, "push+pop full");
    wait_drain("pushpop");
    bus(1'b1, 1'b0, 9'h1F8, 32'h3, 1'b0, 32'h0, 1'b1, "w1c keep en");
    bus(1'b0, 1'b1, 9'h1F4, 32'h0, 1'b1, 32'h02, 1'b1, "ovf cleared");
    bus(1'b0, 1'b1, 9'h1F8, 32'h0, 1'b1, 32'h01, 1'b1, "en kept");

    // Reset during DATA aborts the frame.
    mon_en = 1'b0;
    store_tx(8'h3C, 1'b0);
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("in frame before reset", tx_busy, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("tx after mid-frame reset", tx, 1'b1);
    chk("busy after mid-frame reset", tx_busy, 1'b0);
    bus(1'b0, 1'b1, 9'h1F4, 32'h0, 1'b1, 32'h02, 1'b1, "post-reset status");
    bus(1'b0, 1'b1, 9'h1F8, 32'h0, 1'b1, 32'h00, 1'b1, "post-reset ctrl");
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) n++;
    end
    chk("no frame after reset", n, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
